// File: rtl/stream_packer_if.sv
// stream_packer_if: narrow beat input and packed word output of stream_packer
interface stream_packer_if #(
  parameter int IN_WIDTH = 8,
  parameter int RATIO = 4
);
  logic [IN_WIDTH-1:0] in_data;
  logic in_valid;
  logic in_last;
  logic in_ready;
  logic [IN_WIDTH*RATIO-1:0] out_data;
  logic [$clog2(RATIO):0] out_count;
  logic out_last;
  logic out_valid;
  logic out_ready;
  modport master (
    output in_data, in_valid, in_last, out_ready,
    input in_ready, out_data, out_count, out_last, out_valid
  );
  modport slave (
    input in_data, in_valid, in_last, out_ready,
    output in_ready, out_data, out_count, out_last, out_valid
  );
endinterface

// File: rtl/stream_packer.sv
// stream_packer: packs RATIO narrow beats into one wide word; STREAM_PACKER_MSB_FIRST_EN places the first beat in the MSBs
module stream_packer #(
  parameter int IN_WIDTH = 8,
  parameter int RATIO = 4
) (
  input logic clk,
  input logic rst,
  stream_packer_if.slave bus
);
  localparam int OUT_WIDTH = IN_WIDTH * RATIO;
  localparam int IW = $clog2(RATIO);
  localparam int CW = $clog2(RATIO) + 1;
  if (RATIO < 2) begin : g_bad_ratio
    $error("stream_packer: RATIO must be >= 2");
  end
  logic [OUT_WIDTH-1:0] acc;
  logic [OUT_WIDTH-1:0] merged;
  logic [IW-1:0] idx;
  logic [IW-1:0] lane;
  logic w_en;
  logic r_en;
  logic done;
  assign bus.in_ready = !bus.out_valid || bus.out_ready;
  assign w_en = bus.in_valid && bus.in_ready;
  assign r_en = bus.out_valid && bus.out_ready;
  assign done = idx == IW'(RATIO - 1) || bus.in_last;
`ifdef STREAM_PACKER_MSB_FIRST_EN
  assign lane = IW'(RATIO - 1) - idx;
`else
  assign lane = idx;
`endif
  // acc is cleared on every completion, so unwritten lanes are already zero
  always_comb begin
    merged = acc;
    merged[lane*IN_WIDTH +: IN_WIDTH] = bus.in_data;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      acc <= '0;
      idx <= '0;
      bus.out_data <= '0;
      bus.out_count <= '0;
      bus.out_last <= 1'b0;
      bus.out_valid <= 1'b0;
    end else begin
      if (r_en) bus.out_valid <= 1'b0;
      if (w_en && done) begin
        acc <= '0;
        idx <= '0;
        bus.out_data <= merged;
        bus.out_count <= CW'(idx) + CW'(1);
        bus.out_last <= bus.in_last;
        bus.out_valid <= 1'b1;
      end else if (w_en) begin
        acc <= merged;
        idx <= idx + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_stream_packer.sv
// tb_stream_packer: directed and random checks of stream_packer against a queue-based packing model
module tb_stream_packer;
  localparam int IW = 8;
  localparam int R = 4;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int errors = 0;
  logic [7:0] cur[$];
  logic e_valid = 1'b0;
  logic [31:0] e_data = '0;
  int e_count = 0;
  logic e_last = 1'b0;
  stream_packer_if #(.IN_WIDTH(IW), .RATIO(R)) bus ();
  stream_packer #(.IN_WIDTH(IW), .RATIO(R)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  function automatic logic [31:0] pack_word();
    logic [31:0] w = '0;
    for (int k = 0; k < cur.size(); k++) begin
`ifdef STREAM_PACKER_MSB_FIRST_EN
      w |= 32'(cur[k]) << (IW * (R - 1 - k));
`else
      w |= 32'(cur[k]) << (IW * k);
`endif
    end
    return w;
  endfunction
  task automatic cyc(input logic r, input logic v, input logic [7:0] d, input logic l, input logic ordy);
    logic rdy;
    @(posedge clk);
    #1;
    rst = r;
    bus.in_valid = v;
    bus.in_data = d;
    bus.in_last = l;
    bus.out_ready = ordy;
    @(negedge clk);
    rdy = !e_valid || ordy;
    chk("out_valid", 64'(bus.out_valid), 64'(e_valid));
    chk("out_data", 64'(bus.out_data), 64'(e_data));
    chk("out_count", 64'(bus.out_count), 64'(e_count));
    chk("out_last", 64'(bus.out_last), 64'(e_last));
    chk("in_ready", 64'(bus.in_ready), 64'(rdy));
    if (r) begin
      cur.delete();
      e_valid = 1'b0;
      e_data = '0;
      e_count = 0;
      e_last = 1'b0;
    end else begin
      if (e_valid && ordy) e_valid = 1'b0;
      if (v && rdy) begin
        cur.push_back(d);
        if (cur.size() == R || l) begin
          e_data = pack_word();
          e_count = cur.size();
          e_last = l;
          e_valid = 1'b1;
          cur.delete();
        end
      end
    end
  endtask
  initial begin
    bus.in_valid = 1'b0;
    bus.in_data = '0;
    bus.in_last = 1'b0;
    bus.out_ready = 1'b1;
    cyc(1, 0, 8'h00, 0, 1);
    cyc(0, 0, 8'h00, 0, 1);
    for (int i = 1; i <= 4; i++) cyc(0, 1, 8'(i * 8'h11), 0, 1);
    cyc(0, 0, 8'h00, 0, 1);
`ifdef STREAM_PACKER_MSB_FIRST_EN
    chk("word_full", 64'(bus.out_data), 64'h11223344);
`else
    chk("word_full", 64'(bus.out_data), 64'h44332211);
`endif
    cyc(0, 0, 8'h00, 0, 1);
    chk("valid_one_cycle", 64'(bus.out_valid), 64'd0);
    cyc(0, 1, 8'hA1, 0, 1);
    cyc(0, 1, 8'hB2, 1, 1);
    cyc(0, 0, 8'h00, 0, 1);
`ifdef STREAM_PACKER_MSB_FIRST_EN
    chk("word_last2", 64'(bus.out_data), 64'hA1B20000);
`else
    chk("word_last2", 64'(bus.out_data), 64'h0000B2A1);
`endif
    chk("count_last2", 64'(bus.out_count), 64'd2);
    for (int i = 0; i < 12; i++) cyc(0, 1, 8'(i + 1), 0, 1);
    for (int i = 0; i < 2; i++) cyc(0, 0, 8'h00, 0, 1);
    for (int i = 0; i < 4; i++) cyc(0, 1, 8'(8'hC0 + i), 0, 1);
    for (int i = 0; i < 5; i++) cyc(0, 1, 8'h55, 0, 0);
    chk("bp_in_ready", 64'(bus.in_ready), 64'd0);
    cyc(0, 1, 8'h55, 0, 1);
    for (int i = 0; i < 3; i++) cyc(0, 1, 8'(8'h56 + i), 0, 1);
    cyc(0, 0, 8'h00, 0, 1);
    cyc(0, 1, 8'hEE, 0, 1);
    cyc(0, 1, 8'hEF, 0, 1);
    cyc(1, 0, 8'h00, 0, 1);
    for (int i = 1; i <= 4; i++) cyc(0, 1, 8'(i), 0, 1);
    cyc(0, 0, 8'h00, 0, 1);
`ifdef STREAM_PACKER_MSB_FIRST_EN
    chk("word_after_rst", 64'(bus.out_data), 64'h01020304);
`else
    chk("word_after_rst", 64'(bus.out_data), 64'h04030201);
`endif
    cyc(0, 1, 8'h11, 0, 1);
    cyc(0, 1, 8'h22, 0, 1);
    cyc(0, 1, 8'h33, 1, 1);
    cyc(0, 0, 8'h00, 0, 1);
`ifdef STREAM_PACKER_MSB_FIRST_EN
    chk("word_last3", 64'(bus.out_data), 64'h11223300);
`else
    chk("word_last3", 64'(bus.out_data), 64'h00332211);
`endif
    chk("count_last3", 64'(bus.out_count), 64'd3);
    chk("last_last3", 64'(bus.out_last), 64'd1);
    for (int i = 0; i < 400; i++)
      cyc($urandom_range(0, 99) == 0, $urandom_range(0, 3) != 0, 8'($urandom),
          $urandom_range(0, 7) == 0, $urandom_range(0, 3) != 0);
    for (int i = 0; i < 3; i++) cyc(0, 0, 8'h00, 0, 1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
